// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_pkg
//  Description : Shared constants, pattern type and digit-enable helper for
//                the 4-digit multiplexed 7-segment display driver.
//  Revision    : 1.0  initial release
// ============================================================================
package sseg_pkg;

   localparam int         SSEG_NDIG = 4;
   localparam logic [7:0] SSEG_OFF  = 8'hFF;
   localparam logic [3:0] AN_OFF    = 4'b1111;

   // Active-low pattern: bit7 = dp, bits 6:0 = segments g..a
   typedef logic [7:0] sseg_pat_t;

   // One-hot-low digit enable for the selected digit
   function automatic logic [3:0] an_onehot(input logic [1:0] sel);
      return ~(4'b0001 << sel);
   endfunction

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_refresh_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_refresh_cnt
//  Description : Free-running N-bit refresh counter; the top two bits pick
//                the digit, the rest give the position inside the digit slot.
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_refresh_cnt
   import sseg_pkg::*;
#(
   parameter int N = 18
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic [N-1:0]                 o_q,
   output logic [$clog2(SSEG_NDIG)-1:0] o_sel,
   output logic                         o_frame_last,
   output logic [N-3:0]                 o_slot_pos
);

   logic [N-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         r_q <= r_q + 1'b1;
      end
   end

   assign o_q          = r_q;
   assign o_sel        = r_q[N-1:N-2];
   assign o_frame_last = &r_q;
   assign o_slot_pos   = r_q[N-3:0];

endmodule : sseg_refresh_cnt
`default_nettype wire

// File: rtl/sseg_disp_mux.sv
`default_nettype none
// ============================================================================
//  Module      : sseg_disp_mux
//  Description : Time-multiplexed 4-digit common-anode 7-segment driver with
//                strobed, frame-aligned update of the displayed patterns.
//                Optional anti-ghost blanking at the start of each digit slot
//                is enabled by defining SSEG_GHOST_BLANK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module sseg_disp_mux
   import sseg_pkg::*;
#(
   parameter int N         = 18,
   parameter int BLANK_CYC = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] in0,
   input  logic [7:0] in1,
   input  logic [7:0] in2,
   input  logic [7:0] in3,
   input  logic       upd,
   output logic [3:0] an,
   output logic [7:0] sseg,
   output logic       frame_tick
);

   // Elaboration-time parameter sanity
   if (N < 3) begin : g_chk_n
      $error("sseg_disp_mux: N must be at least 3");
   end
   if (BLANK_CYC >= (2 ** (N - 2))) begin : g_chk_blank
      $error("sseg_disp_mux: BLANK_CYC must be smaller than one digit slot");
   end

   logic [N-1:0] w_unused_q;
   logic [1:0]   w_sel;
   logic         w_frame_last;
   logic [N-3:0] w_slot_pos;
   logic         w_frame_start;
   logic         w_blank;
   sseg_pat_t    w_in [SSEG_NDIG];

   sseg_pat_t    r_pend   [SSEG_NDIG];
   sseg_pat_t    r_active [SSEG_NDIG];
   logic         r_pend_vld;
   logic [3:0]   r_an;
   sseg_pat_t    r_sseg;
   logic         r_frame_tick;

   sseg_refresh_cnt #(
      .N (N)
   ) u_refresh_cnt (
      .clk          (clk),
      .reset        (reset),
      .o_q          (w_unused_q),
      .o_sel        (w_sel),
      .o_frame_last (w_frame_last),
      .o_slot_pos   (w_slot_pos)
   );

   assign w_in[0] = in0;
   assign w_in[1] = in1;
   assign w_in[2] = in2;
   assign w_in[3] = in3;

   assign w_frame_start = (w_sel == 2'd0) && (w_slot_pos == '0);

`ifdef SSEG_GHOST_BLANK_EN
   localparam logic [N-3:0] c_blank_cyc = BLANK_CYC[N-3:0];
   assign w_blank = (w_slot_pos < c_blank_cyc);
`else
   assign w_blank = 1'b0;
`endif

   // Displayed data only moves at the frame boundary; an update landing on
   // the boundary itself bypasses the pending stage so it is not lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SSEG_NDIG; i++) begin
            r_pend[i]   <= SSEG_OFF;
            r_active[i] <= SSEG_OFF;
         end
         r_pend_vld <= 1'b0;
      end else if (w_frame_last && upd) begin
         for (int i = 0; i < SSEG_NDIG; i++) begin
            r_active[i] <= w_in[i];
         end
         r_pend_vld <= 1'b0;
      end else if (w_frame_last && r_pend_vld) begin
         for (int i = 0; i < SSEG_NDIG; i++) begin
            r_active[i] <= r_pend[i];
         end
         r_pend_vld <= 1'b0;
      end else if (upd) begin
         for (int i = 0; i < SSEG_NDIG; i++) begin
            r_pend[i] <= w_in[i];
         end
         r_pend_vld <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_an         <= AN_OFF;
         r_sseg       <= SSEG_OFF;
         r_frame_tick <= 1'b0;
      end else begin
         r_frame_tick <= w_frame_start;
         if (w_blank) begin
            r_an   <= AN_OFF;
            r_sseg <= SSEG_OFF;
         end else begin
            r_an   <= an_onehot(w_sel);
            r_sseg <= r_active[w_sel];
         end
      end
   end

   assign an         = r_an;
   assign sseg       = r_sseg;
   assign frame_tick = r_frame_tick;

endmodule : sseg_disp_mux
`default_nettype wire
